// File: rtl/cycle_step_arbiter_pkg.sv
// Shared encodings, controller states and ring-index helpers for cycle_step_arbiter.
package cycle_step_arbiter_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STEP,
        GAP,
        DONE
    } ctrl_state_e;

    // Position of a state along the advance ring S0 -> S3 -> S1 -> S2.
    function automatic logic [1:0] idx(input logic [1:0] s);
        case (s)
            S0:      idx = 2'd0;
            S3:      idx = 2'd1;
            S1:      idx = 2'd2;
            default: idx = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] ring_state(input logic [1:0] i);
        case (i)
            2'd0:    ring_state = S0;
            2'd1:    ring_state = S3;
            2'd2:    ring_state = S1;
            default: ring_state = S2;
        endcase
    endfunction

endpackage

// File: rtl/cycle_step_arbiter_cycle4_fsm.sv
// Four-state cyclic sequence register; moves one ring position per step pulse.
module cycle4_fsm
    import cycle_step_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_b,
    input  logic       step,
    output logic [1:0] state
);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= S0;
        end else if (step) begin
            state <= ring_state(idx(state) + 2'd1);
        end
    end

endmodule

// File: rtl/cycle_step_arbiter.sv
// Round-robin owner of the cyclic sequence machine: grants one requester,
// pulses step until the latched target is reached, then pulses done.
module cycle_step_arbiter
    import cycle_step_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 0
)
(
    input  logic       clock,
    input  logic       reset_b,
    input  logic [1:0] req,
    input  logic [1:0] target0,
    input  logic [1:0] target1,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       step,
    output logic [1:0] state,
    output logic       busy
);

    ctrl_state_e       ctrl_q, ctrl_d;
    logic [1:0]        target_q, target_d;
    logic [1:0]        grant_d, done_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              winner_c;
    logic              step_d, busy_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    cycle4_fsm u_cycle4_fsm (
        .clock   (clock),
        .reset_b (reset_b),
        .step    (step),
        .state   (state)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            ctrl_q   <= IDLE;
            target_q <= S0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            gap_q    <= '0;
            grant    <= 2'b00;
            done     <= 2'b00;
            step     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            target_q <= target_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
            grant    <= grant_d;
            done     <= done_d;
            step     <= step_d;
            busy     <= busy_d;
        end
    end

    // Next-state and next-output decode; outputs are registered from ctrl_d.
    always_comb begin
        ctrl_d   = ctrl_q;
        target_d = target_q;
        owner_d  = owner_q;
        last_d   = last_q;
        gap_d    = gap_q;
        grant_d  = grant;
        winner_c = 1'b0;

        // Tie goes to whoever was not served last.
        case (req)
            2'b10:   winner_c = 1'b1;
            2'b11:   winner_c = ~last_q;
            default: winner_c = 1'b0;
        endcase

        case (ctrl_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d  = winner_c;
                    target_d = winner_c ? target1 : target0;
                    grant_d  = winner_c ? 2'b10 : 2'b01;
                    ctrl_d   = CHECK;
                end
            end
            CHECK: begin
                ctrl_d = (state == target_q) ? DONE : STEP;
            end
            STEP: begin
                if (HOLD_CYCLES > 0) begin
                    ctrl_d = GAP;
                    gap_d  = GAP_W'(HOLD_CYCLES - 1);
                end else begin
                    ctrl_d = CHECK;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    ctrl_d = CHECK;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                last_d  = owner_q;
                grant_d = 2'b00;
                ctrl_d  = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                ctrl_d  = IDLE;
            end
        endcase

        step_d = (ctrl_d == STEP);
        busy_d = (ctrl_d != IDLE);
        done_d = (ctrl_d == DONE) ? grant_d : 2'b00;
    end

endmodule

// File: tb/tb_cycle_step_arbiter.sv
// Randomized self-checking bench for cycle_step_arbiter (HOLD_CYCLES 0 and 2 instances).
module tb_cycle_step_arbiter;

    logic       clock;
    logic       reset_b;
    logic [1:0] req_a, t0_a, t1_a, grant_a, done_a, state_a;
    logic       step_a, busy_a;
    logic [1:0] req_b, t0_b, t1_b, grant_b, done_b, state_b;
    logic       step_b, busy_b;

    int n_tests;
    int n_fail;

    // Reference model: ring position of the machine and last-served requester.
    int m_idx [2];
    bit m_last[2];
    int hold_of[2];
    logic [1:0] ring_lut[4];

    cycle_step_arbiter #(.HOLD_CYCLES(0)) dut_a (
        .clock(clock), .reset_b(reset_b), .req(req_a), .target0(t0_a), .target1(t1_a),
        .grant(grant_a), .done(done_a), .step(step_a), .state(state_a), .busy(busy_a)
    );

    cycle_step_arbiter #(.HOLD_CYCLES(2)) dut_b (
        .clock(clock), .reset_b(reset_b), .req(req_b), .target0(t0_b), .target1(t1_b),
        .grant(grant_b), .done(done_b), .step(step_b), .state(state_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int ring_pos(input logic [1:0] s);
        for (int i = 0; i < 4; i++) begin
            if (ring_lut[i] == s) return i;
        end
        return 0;
    endfunction

    function automatic logic [1:0] o_grant(input int inst);
        return (inst == 0) ? grant_a : grant_b;
    endfunction
    function automatic logic [1:0] o_done(input int inst);
        return (inst == 0) ? done_a : done_b;
    endfunction
    function automatic logic [1:0] o_state(input int inst);
        return (inst == 0) ? state_a : state_b;
    endfunction
    function automatic logic o_step(input int inst);
        return (inst == 0) ? step_a : step_b;
    endfunction
    function automatic logic o_busy(input int inst);
        return (inst == 0) ? busy_a : busy_b;
    endfunction

    task automatic drive(input int inst, input logic [1:0] r, input logic [1:0] a, input logic [1:0] b);
        if (inst == 0) begin
            req_a = r; t0_a = a; t1_a = b;
        end else begin
            req_b = r; t0_b = a; t1_b = b;
        end
    endtask

    // Assert reset asynchronously mid-cycle and check every output clears at once.
    task automatic apply_reset(input string tag);
        #($urandom_range(1, 4));
        reset_b = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_state(k) !== 2'b00 || o_grant(k) !== 2'b00 || o_busy(k) !== 1'b0 ||
                o_step(k) !== 1'b0 || o_done(k) !== 2'b00) begin
                n_fail++;
                $display("FAIL %s inst%0d: state=%b grant=%b busy=%b step=%b done=%b, want all zero",
                         tag, k, o_state(k), o_grant(k), o_busy(k), o_step(k), o_done(k));
            end
        end
        drive(0, 2'b00, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b00, 2'b00);
        @(negedge clock);
        @(negedge clock);
        reset_b = 1'b1;
        m_idx[0] = 0; m_idx[1] = 0;
        m_last[0] = 1'b1; m_last[1] = 1'b1;
    endtask

    // One full request/grant/step/done transaction checked against the model.
    task automatic run_txn(input int inst, input logic [1:0] r, input logic [1:0] a,
                           input logic [1:0] b, input bit hold);
        int w, tgt, n, lat, done_cyc, nsteps, exp_pos;
        bit prev_step, consec;
        logic [1:0] exp_grant, done_val, grant_at_done, state_at_done;

        w = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : (m_last[inst] ? 0 : 1);
        tgt = ring_pos((w == 1) ? b : a);
        n = (tgt - m_idx[inst] + 4) % 4;
        lat = 2 + n * (2 + hold_of[inst]);
        exp_grant = (w == 0) ? 2'b01 : 2'b10;

        @(negedge clock);
        drive(inst, r, a, b);
        @(posedge clock);
        #1;
        n_tests++;
        if (o_grant(inst) !== exp_grant || o_busy(inst) !== 1'b1) begin
            n_fail++;
            $display("FAIL grant inst%0d: grant=%b busy=%b, want grant=%b busy=1",
                     inst, o_grant(inst), o_busy(inst), exp_grant);
        end
        // Targets and req change after grant must not matter.
        drive(inst, hold ? r : 2'b00, 2'($urandom), 2'($urandom));

        done_cyc = -1; nsteps = 0; prev_step = 1'b0; consec = 1'b0; exp_pos = m_idx[inst];
        done_val = 2'b00; grant_at_done = 2'b00; state_at_done = 2'b00;
        for (int c = 1; c <= lat + 4; c++) begin
            @(posedge clock);
            #1;
            if (prev_step) begin
                exp_pos = (exp_pos + 1) % 4;
                n_tests++;
                if (o_state(inst) !== ring_lut[exp_pos]) begin
                    n_fail++;
                    $display("FAIL state_advance inst%0d: state=%b want %b",
                             inst, o_state(inst), ring_lut[exp_pos]);
                end
            end
            if (o_step(inst) === 1'b1) begin
                nsteps++;
                if (prev_step) consec = 1'b1;
            end
            prev_step = (o_step(inst) === 1'b1);
            if (o_done(inst) !== 2'b00) begin
                done_cyc = c;
                done_val = o_done(inst);
                grant_at_done = o_grant(inst);
                state_at_done = o_state(inst);
                break;
            end
        end

        // done is visible in the cycle closed by edge k+lat, i.e. sampled after edge k+lat-1.
        n_tests++;
        if (done_cyc != lat - 1) begin
            n_fail++;
            $display("FAIL done_latency inst%0d: done seen after %0d edges, want %0d (N=%0d)",
                     inst, done_cyc, lat - 1, n);
        end
        if (done_cyc >= 0) begin
            n_tests++;
            if (done_val !== exp_grant || grant_at_done !== exp_grant) begin
                n_fail++;
                $display("FAIL done_owner inst%0d: done=%b grant=%b want %b",
                         inst, done_val, grant_at_done, exp_grant);
            end
            n_tests++;
            if (state_at_done !== ring_lut[tgt]) begin
                n_fail++;
                $display("FAIL final_state inst%0d: state=%b want %b", inst, state_at_done, ring_lut[tgt]);
            end
            n_tests++;
            if (nsteps != n || consec) begin
                n_fail++;
                $display("FAIL step_count inst%0d: steps=%0d back_to_back=%0d want steps=%0d back_to_back=0",
                         inst, nsteps, consec, n);
            end
            @(posedge clock);
            #1;
            n_tests++;
            if (o_grant(inst) !== 2'b00 || o_busy(inst) !== 1'b0 || o_done(inst) !== 2'b00) begin
                n_fail++;
                $display("FAIL back_to_idle inst%0d: grant=%b busy=%b done=%b want 00/0/00",
                         inst, o_grant(inst), o_busy(inst), o_done(inst));
            end
        end
        m_last[inst] = (w == 1);
        m_idx[inst] = tgt;
    endtask

    task automatic test_reset();
        apply_reset("reset_initial");
        @(negedge clock);
        drive(0, 2'b01, 2'b10, 2'b00);
        drive(1, 2'b10, 2'b00, 2'b10);
        repeat (2) @(posedge clock);
        drive(0, 2'b00, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b00, 2'b00);
        repeat ($urandom_range(0, 3)) @(posedge clock);
        apply_reset("reset_async");
    endtask

    task automatic test_three_steps();
        apply_reset("reset_three_steps");
        run_txn(0, 2'b01, 2'b10, 2'b00, 1'b0);
    endtask

    task automatic test_zero_steps();
        run_txn(0, 2'b01, 2'b11, 2'b00, 1'b0);
        run_txn(0, 2'b10, 2'b00, 2'b11, 1'b0);
    endtask

    task automatic test_tie();
        apply_reset("reset_tie");
        run_txn(0, 2'b11, 2'($urandom), 2'($urandom), 1'b1);
        run_txn(0, 2'b11, 2'($urandom), 2'($urandom), 1'b1);
        run_txn(0, 2'b11, 2'($urandom), 2'($urandom), 1'b1);
        @(negedge clock);
        drive(0, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_spacing();
        run_txn(1, 2'b01, ring_lut[(m_idx[1] + 1) % 4], 2'b00, 1'b0);
        run_txn(1, 2'b10, 2'b00, ring_lut[(m_idx[1] + 3) % 4], 1'b0);
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        apply_reset("reset_before_mid_op");
        @(negedge clock);
        drive(1, 2'b01, 2'b10, 2'b00);
        @(posedge clock);
        #1;
        drive(1, 2'b00, 2'b00, 2'b00);
        @(posedge clock);
        @(posedge clock);
        #2;
        apply_reset("reset_in_gap");
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            if (done_b !== 2'b00) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL no_done_after_reset: done pulsed after reset, want none");
        end
        run_txn(1, 2'b11, 2'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 1), 2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 1'b0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        hold_of[0] = 0;
        hold_of[1] = 2;
        ring_lut[0] = 2'b00;
        ring_lut[1] = 2'b11;
        ring_lut[2] = 2'b01;
        ring_lut[3] = 2'b10;
        m_idx[0] = 0; m_idx[1] = 0;
        m_last[0] = 1'b1; m_last[1] = 1'b1;
        reset_b = 1'b0;
        drive(0, 2'b00, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b00, 2'b00);
        #12;
        reset_b = 1'b1;

        test_reset();
        test_three_steps();
        test_zero_steps();
        test_tie();
        test_spacing();
        test_reset_mid_op();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cycle_step_arbiter.md
# cycle_step_arbiter

Shares one 4-state cyclic sequence machine between two requesters. Each requester asks for the machine to be moved to a target state. The block arbitrates round-robin, issues single-cycle advance pulses until the machine reaches the granted target, then signals completion. It owns the cyclic state register and sits between the requesting control blocks and any logic that decodes the sequence state.

## Interface
Parameters:
- HOLD_CYCLES, default 0: idle cycles inserted after each advance pulse; legal range 0..15.

Ports:
- clock  input  1  rising-edge clock
- reset_b  input  1  asynchronous, active-low reset
- req  input  2  request per requester; level, sampled only in IDLE
- target0  input  2  target state for requester 0; latched at grant
- target1  input  2  target state for requester 1; latched at grant
- grant  output  2  one-hot owner of the machine; 00 when idle
- done  output  2  one-cycle completion pulse for the owner
- step  output  1  advance pulse; high exactly one cycle per advance
- state  output  2  current cyclic state
- busy  output  1  high in every controller state except IDLE

## Operation
- Cyclic machine: on a cycle with step=1, the state advances 00→11→01→10→00. With step=0 it holds.
- Ring index for the four states: 00=0, 11=1, 01=2, 10=3. Steps needed = (idx(target) − idx(state)) mod 4, range 0..3.
- Controller states are IDLE, CHECK, STEP, GAP and DONE.
- IDLE:
  - If req≠00, pick a winner and latch its target.
  - Set grant one-hot.
  - Go to CHECK.
- Arbitration:
  - A single request wins outright.
  - If both requesters are asking, the winner is the one not served last.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- CHECK:
  - If state == latched target, go to DONE.
  - Otherwise go to STEP.
- STEP:
  - step=1 for this cycle only, and the state advances at the closing edge.
  - Then go to GAP if HOLD_CYCLES>0, else to CHECK.
- GAP: count HOLD_CYCLES cycles, then go to CHECK.
- DONE:
  - done[winner]=1 for this cycle, with grant still held.
  - Update the last-served pointer.
  - Go to IDLE; grant drops at the same edge.
- Behaviour after grant:
  - Changing a target after grant has no effect.
  - Dropping req after grant does not abort the operation; done still pulses.
  - A req still high in IDLE is treated as a new request.
- Reset (asynchronous, any time including mid-operation):
  - Controller goes to IDLE and state goes to 00.
  - grant, done and step go to 0; busy goes to 0.
  - The last-served pointer goes to 1.

## Timing
- Reset values: state=00, grant=00, done=00, step=0, busy=0.
- All outputs are registered or decoded from registered state; no input-to-output combinational paths.
- Request to grant: req high at edge k in IDLE → grant and busy high after edge k.
- Zero-step request: done pulses in cycle k+2, back in IDLE after edge k+2.
- Latency for N steps (N in 0..3): done asserts 2 + N·(2+HOLD_CYCLES) cycles after the sampling edge.
- step never occurs on two consecutive cycles.
- A new grant is possible at the earliest one cycle after DONE.

## Structure
- Shared package holds:
  - the state encodings S0=00, S1=01, S2=10, S3=11;
  - the controller state enum;
  - an idx() ring-index function.
- One sub-module: cycle4_fsm, with inputs clock, reset_b and step, and output state. It implements the advance order above.
- Arbitration, target latch and gap counter live in the top module.

## Test plan
- Reset: reset_b low at an arbitrary time → state=00, grant=00, busy=0, step=0.
- Three steps, HOLD_CYCLES=0, state 00: req=01 with target0=10 → three step pulses, states 11, 01, 10, then done=01 exactly 8 cycles after the sampling edge.
- Zero steps: state=11, req=10 with target1=11 → no step, done=10 two cycles after the sampling edge.
- Tie: req=11 from reset → grant=01 first; with req held, the next grant is 10, then 01.
- Spacing: HOLD_CYCLES=2, one-step request → step high exactly 1 cycle, done 2+4=6 cycles after the sampling edge.
- Reset mid-operation: assert reset_b low during GAP of a 3-step request → state=00 immediately, no done pulse; a new req afterwards is granted to requester 0.
